muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide engine that owns the HI/LO special-purpose registers.
- Sits beside the ALU in the execute stage: the ALU issues MULT/MULTU/DIV/DIVU here and reads HI/LO back for MFHI/MFLO.
- Replaces the single-cycle combinational multiply and divide.
- Controller stalls the pipeline on `busy`.

Parameters:
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- `clock`      input   1      system clock, rising-edge
- `reset`      input   1      synchronous, active-high
- `start`      input   1      launch operation; sampled only in IDLE or DONE
- `op`         input   2      operation, muldiv_op_t: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `a`          input   WIDTH  multiplicand / dividend (rs)
- `b`          input   WIDTH  multiplier / divisor (rt)
- `hi_we`      input   1      MTHI write enable
- `lo_we`      input   1      MTLO write enable
- `wd`         input   WIDTH  MTHI/MTLO write data
- `busy`       output  1      operation in progress; pipeline must stall MF*/MT*/new mul-div
- `done`       output  1      one-cycle pulse: HI/LO just updated
- `div_zero`   output  1      sticky flag: last divide had b==0; cleared on next accepted start
- `hi`         output  WIDTH  HI register (product high word / remainder)
- `lo`         output  WIDTH  LO register (product low word / quotient)

Behaviour:
- Interface: one clock (`clock`); reset (`reset`) is synchronous and active-high.
- Reset (synchronous, `reset`=1 at an edge): state=IDLE; `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0; iteration counter=0. Reset mid-operation aborts with no HI/LO update.
- FSM states: IDLE, BUSY, DONE.
  - IDLE/DONE + `start`=1 → BUSY. On that edge: latch op; latch |a|, |b| (magnitudes if signed op, raw otherwise); latch result signs; counter=WIDTH-1; clear `div_zero`.
  - BUSY, counter>0 → BUSY; one iteration per edge; counter decrements.
  - BUSY, counter==0 → DONE. On that edge: apply sign fix-up, write `hi`/`lo`, set `done`.
  - DONE + `start`=0 → IDLE. DONE + `start`=1 → BUSY (back-to-back launch allowed).
- Latency: start accepted at edge E0; `busy`=1 after E0 through E_WIDTH; `hi`/`lo` valid and `done`=1 for exactly one cycle after E_WIDTH. Total is WIDTH+1 edges from start to done.
- Multiply: radix-2 shift-add on magnitudes into a 2*WIDTH accumulator.
  - MULT result negated (two's complement, 2*WIDTH bits) if sign(a)^sign(b).
  - {hi,lo} = product.
- Divide: restoring, one quotient bit per iteration.
  - DIV quotient negated if sign(a)^sign(b); remainder takes sign of a.
  - lo=quotient, hi=remainder.
  - DIV of 0x80000000 by 0xFFFFFFFF yields lo=0x80000000, hi=0 with no special case.
- Divide by zero (b==0): runs the full latency; result lo=all ones, hi=a (original, unsigned view); `div_zero`=1 from done onward.
- `start` while BUSY: ignored. Operands are not re-sampled; the caller must hold the pipeline on `busy`.
- `hi_we`/`lo_we`: applied at the edge in IDLE or DONE; ignored in BUSY.
  - Coincident with the final BUSY edge: the divide/multiply result wins.
  - Coincident with an accepted `start`: the write is applied, and the new operation overwrites HI/LO later.
- `hi`/`lo` are registered outputs and hold their value between operations.

Decomposition:
- Package `globals`:
  - typedef enum logic[1:0] muldiv_op_t {MD_MULTU, MD_MULT, MD_DIVU, MD_DIV}
  - typedef enum logic[1:0] muldiv_state_t {MD_IDLE, MD_BUSY, MD_DONE}
  - localparam MD_ITER = 32
- Sub-module: `abs_val` (WIDTH param; outputs magnitude and sign bit). Instantiated for a and b; reused via a negate path for fix-up.
- HI/LO stay local registers. The existing enabled register block is not reused because write priority is FSM-controlled.

Test Plan:
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 33 edges `done`=1, hi=0xFFFFFFFE, lo=0x00000001; `busy` high for exactly 32 cycles.
- MULT a=0xFFFFFFFD(-3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB(-21); then DIV a=-7 b=2 → lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
- DIVU a=100 b=7 → lo=14, hi=2, `div_zero`=0. Then DIVU a=5 b=0 → lo=0xFFFFFFFF, hi=5, `div_zero`=1. Next start clears `div_zero` at the launch edge.
- Pulse `start` with new operands during BUSY, plus `hi_we`=1 wd=0xDEAD → the original result is delivered unchanged and HI is not 0xDEAD.
- `reset`=1 at iteration 10 of a DIV → next cycle `busy`=0, hi=lo=0, state IDLE; a new start completes normally.
- Back-to-back: `start` held high in DONE → second op launches with no IDLE cycle. Also: `lo_we` wd=0x1234 in IDLE → lo=0x1234 next cycle.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared types and constants for the multiply/divide engine
package muldiv_unit_pkg;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit_abs_val.sv
// rtl/muldiv_unit_abs_val.sv - magnitude and sign of an operand
// Unsigned operands pass through untouched with sign forced low.
module abs_val #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  always_comb begin
    sign = is_signed & value[WIDTH-1];
    mag  = sign ? -value : value;
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide engine owning HI/LO
// One shift-add or restoring-divide step per clock on magnitudes; signs fixed on the last step.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               pneg_q, pneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               a_sign, b_sign;
  logic               in_signed;

  assign in_signed = op[0];

  abs_val #(.WIDTH(WIDTH)) u_abs_a (
    .value    (a),
    .is_signed(in_signed),
    .mag      (a_mag),
    .sign     (a_sign)
  );

  abs_val #(.WIDTH(WIDTH)) u_abs_b (
    .value    (b),
    .is_signed(in_signed),
    .mag      (b_mag),
    .sign     (b_sign)
  );

  logic               is_div;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_top;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] iter_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    is_div    = (op_q == MD_DIVU) || (op_q == MD_DIV);
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    rem_top   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = rem_top - {1'b0, opnd_q};
    div_ok    = ~div_diff[WIDTH];
    div_next  = {div_ok ? div_diff[WIDTH-1:0] : rem_top[WIDTH-1:0], acc_q[WIDTH-2:0], div_ok};
    iter_next = is_div ? div_next : mul_next;

    prod_fix  = pneg_q ? -iter_next : iter_next;
    quot_fix  = pneg_q ? -iter_next[WIDTH-1:0] : iter_next[WIDTH-1:0];
    rem_fix   = rneg_q ? -iter_next[2*WIDTH-1:WIDTH] : iter_next[2*WIDTH-1:WIDTH];

    if (!is_div) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (dz_q) begin
      res_hi = a_raw_q;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = rem_fix;
      res_lo = quot_fix;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    a_raw_d    = a_raw_q;
    pneg_d     = pneg_q;
    rneg_d     = rneg_q;
    dz_d       = dz_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    case (state_q)
      MD_IDLE, MD_DONE: begin
        if (hi_we) hi_d = wd;
        if (lo_we) lo_d = wd;
        if (start) begin
          state_d    = MD_BUSY;
          op_d       = muldiv_op_t'(op);
          cnt_d      = CW'(WIDTH - 1);
          acc_d      = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          opnd_d     = op[1] ? b_mag : a_mag;
          a_raw_d    = a;
          pneg_d     = a_sign ^ b_sign;
          rneg_d     = a_sign;
          dz_d       = op[1] && (b == {WIDTH{1'b0}});
          div_zero_d = 1'b0;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_BUSY: begin
        acc_d = iter_next;
        if (cnt_q == {CW{1'b0}}) begin
          state_d = MD_DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
          done_d  = 1'b1;
          if (dz_q) div_zero_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase

    busy_d = (state_d == MD_BUSY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= MD_IDLE;
      op_q       <= MD_MULTU;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      a_raw_q    <= '0;
      pneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      a_raw_q    <= a_raw_d;
      pneg_q     <= pneg_d;
      rneg_q     <= rneg_d;
      dz_q       <= dz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wd = 32'h0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .wd      (wd),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the architectural divide-by-zero result.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
    longint sx, sy, r;
    logic [63:0] u;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    edz = 1'b0;
    case (o)
      2'b00: begin u = {32'h0, x} * {32'h0, y}; ehi = u[63:32]; elo = u[31:0]; end
      2'b01: begin r = sx * sy; u = r; ehi = u[63:32]; elo = u[31:0]; end
      default: begin
        if (y == 32'h0) begin
          edz = 1'b1; ehi = x; elo = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          elo = x / y; ehi = x % y;
        end else begin
          r = sx / sy; u = r; elo = u[31:0];
          r = sx % sy; u = r; ehi = u[31:0];
        end
      end
    endcase
  endtask

  // Launch at the next edge; returns on the falling edge just after the launch edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_done(output int bc, output logic seen);
    bc = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin seen = 1'b1; break; end
      if (busy) bc++;
      @(negedge clock);
    end
  endtask

  task automatic run_check(input string nm, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                           input logic edz);
    int bc;
    logic seen;
    launch(o, x, y);
    wait_done(bc, seen);
    check({nm, " done"}, 32'(seen), 32'd1);
    check({nm, " busy_cycles"}, bc, 32'd32);
    check({nm, " hi"}, hi, ehi);
    check({nm, " lo"}, lo, elo);
    check({nm, " div_zero"}, 32'(div_zero), 32'(edz));
  endtask

  initial begin
    vec_t vecs[$];
    int bc;
    logic seen;
    logic [31:0] ehi, elo, rb;
    logic edz;
    logic [1:0] ro;

    vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
    vecs.push_back('{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
    vecs.push_back('{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0});
    vecs.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0});
    vecs.push_back('{2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1});
    vecs.push_back('{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0});
    vecs.push_back('{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1});

    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].ehi, vecs[i].elo, vecs[i].edz);

    // Sticky flag from the last vector clears on the launch edge of the next op.
    launch(2'b00, 32'd2, 32'd3);
    check("dz cleared at launch", 32'(div_zero), 32'd0);
    check("busy after launch", 32'(busy), 32'd1);
    wait_done(bc, seen);
    check("post-dz mult lo", lo, 32'd6);

    // Start and MTHI during BUSY must be ignored.
    launch(2'b10, 32'd100, 32'd7);
    repeat (3) @(negedge clock);
    start = 1'b1; op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0; hi_we = 1'b1; wd = 32'hDEAD;
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0;
    wait_done(bc, seen);
    check("busy-start done", 32'(seen), 32'd1);
    check("busy-start lo", lo, 32'd14);
    check("busy-start hi", hi, 32'd2);
    @(negedge clock);
    check("busy-start no relaunch", 32'(busy), 32'd0);

    // Reset in the middle of a divide aborts without touching HI/LO beyond clearing them.
    launch(2'b11, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(negedge clock);
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid-reset busy", 32'(busy), 32'd0);
    check("mid-reset done", 32'(done), 32'd0);
    check("mid-reset hi", hi, 32'd0);
    check("mid-reset lo", lo, 32'd0);
    run_check("after-reset", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    // Back-to-back: start held in DONE relaunches with no IDLE cycle.
    launch(2'b00, 32'd6, 32'd7);
    wait_done(bc, seen);
    check("b2b first lo", lo, 32'd42);
    start = 1'b1; op = 2'b10; a = 32'd50; b = 32'd5;
    @(negedge clock);
    start = 1'b0;
    check("b2b busy", 32'(busy), 32'd1);
    check("b2b done low", 32'(done), 32'd0);
    wait_done(bc, seen);
    check("b2b second done", 32'(seen), 32'd1);
    check("b2b busy_cycles", bc, 32'd32);
    check("b2b second lo", lo, 32'd10);
    check("b2b second hi", hi, 32'd0);

    // MTLO in IDLE.
    @(negedge clock);
    lo_we = 1'b1; wd = 32'h1234;
    @(negedge clock);
    lo_we = 1'b0;
    check("mtlo lo", lo, 32'h1234);
    check("mtlo hi kept", hi, 32'd0);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1, 2:    rb = $urandom_range(1, 15);
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      model(ro, 32'($urandom), rb, ehi, elo, edz);
      begin
        logic [31:0] ra;
        ra = $urandom;
        model(ro, ra, rb, ehi, elo, edz);
        run_check($sformatf("rnd%0d op%0d a=%h b=%h", i, ro, ra, rb), ro, ra, rb, ehi, elo, edz);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
